s2b_window_counter: RTL and testbench

Stochastic-to-binary converter placed directly downstream of the stochastic square-root stage. It counts the ones in a unipolar bitstream over a fixed window of 2^WIDTH cycles. It then presents the count as a WIDTH-bit binary estimate of the stream probability, with a one-cycle valid pulse. Software and the scoreboard read this value to measure the accuracy of the upstream stochastic operator.

---
 rtl/s2b_window_counter.sv | 92 +++++++++
 tb/tb_s2b_window_counter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/s2b_window_counter.sv
// s2b_window_counter: counts the ones in a unipolar stochastic bitstream over a
// window of 2^WIDTH samples and presents the count as a WIDTH-bit binary estimate
// of the stream probability. The estimate comes with a one-cycle out_valid pulse.
// An all-ones window saturates to 2^WIDTH-1 instead of wrapping to 0.
//
// Optional feature: define S2B_CONTINUOUS_EN for free-running mode. In that mode,
// after the first start, windows run back to back with no gap sample. Only reset
// returns the block to IDLE. With the macro undefined, each start runs one window.
module s2b_window_counter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             in,
    output logic             busy,
    output logic             out_valid,
    output logic [WIDTH-1:0] out
);

    typedef enum logic {StIdle, StRun} state_e;

    state_e           state_q, state_d;
    logic [WIDTH:0]   ones_q, ones_d;    // one extra bit so 2^WIDTH ones is representable
    logic [WIDTH-1:0] win_q, win_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             valid_q, valid_d;

    logic [WIDTH:0]   final_cnt;
    logic             last_sample;

    // The count including the sample taken on the current edge.
    assign final_cnt   = ones_q + {{WIDTH{1'b0}}, in};
    assign last_sample = (win_q == {WIDTH{1'b1}});

    // Next-state and result logic for the IDLE/RUN window sequencer.
    always_comb begin
        state_d = state_q;
        ones_d  = ones_q;
        win_d   = win_q;
        out_d   = out_q;
        valid_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StRun;
                    ones_d  = '0;
                    win_d   = '0;
                end
            end
            StRun: begin
                ones_d = final_cnt;
                win_d  = win_q + 1'b1;
                if (last_sample) begin
                    // Only the full-window count can set the top bit; clamp it to all ones.
                    out_d   = final_cnt[WIDTH] ? {WIDTH{1'b1}} : final_cnt[WIDTH-1:0];
                    valid_d = 1'b1;
                    ones_d  = '0;
                    win_d   = '0;
`ifdef S2B_CONTINUOUS_EN
                    state_d = StRun;
`else
                    state_d = StIdle;
`endif
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State, counters and output registers; reset discards any partial window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            ones_q  <= '0;
            win_q   <= '0;
            out_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ones_q  <= ones_d;
            win_q   <= win_d;
            out_q   <= out_d;
            valid_q <= valid_d;
        end
    end

    assign busy      = (state_q == StRun);
    assign out_valid = valid_q;
    assign out       = out_q;

endmodule

// File: tb/tb_s2b_window_counter.sv
// Self-checking bench for s2b_window_counter with WIDTH=4 (16-sample window).
// The bench runs table-driven single windows, hand-written corner sequences and a
// randomized run against a queue-based reference model.
module tb_s2b_window_counter;

    localparam int unsigned W = 4;
    localparam int unsigned N = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         in = 1'b0;
    logic         busy;
    logic         out_valid;
    logic [W-1:0] out;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    s2b_window_counter #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .in        (in),
        .busy      (busy),
        .out_valid (out_valid),
        .out       (out)
    );

    typedef struct {
        string       name;
        logic [15:0] pat;   // bit i is the i-th sample of the window
        int          exp;
    } vec_t;

    vec_t vecs[7];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Runs one window from IDLE with the given sample pattern and checks the result.
    task automatic run_window(input string name, input logic [15:0] pat, input int exp);
        logic early;
        early = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk({name, "_busy_rise"}, busy, 1);
        for (int i = 0; i < N; i++) begin
            in = pat[i];
            tick();
            if (i < N - 1 && out_valid) early = 1'b1;
        end
        in = 1'b0;
        chk({name, "_no_early_valid"}, early, 0);
        chk({name, "_valid"}, out_valid, 1);
        chk({name, "_out"}, out, exp);
        chk({name, "_busy_fall"}, busy, 0);
        tick();
        chk({name, "_valid_clear"}, out_valid, 0);
        chk({name, "_out_hold"}, out, exp);
    endtask

    initial begin
        int          vcount;
        int          first_at;
        int          second_at;
        logic        saw_valid;
        logic        out_nz;
        logic        busy_m;
        logic        val_m;
        logic [W-1:0] out_m;
        int          q[$];
        int          sum;
        int          p;

        vecs[0] = '{"all_zeros", 16'h0000, 0};
        vecs[1] = '{"all_ones",  16'hFFFF, 15};
        vecs[2] = '{"alt",       16'h5555, 8};
        vecs[3] = '{"low_nib",   16'h000F, 4};
        vecs[4] = '{"fifteen",   16'h7FFF, 15};
        vecs[5] = '{"ends",      16'h8001, 2};
        vecs[6] = '{"one_first", 16'h0001, 1};

        // Reset values
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_out", out, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

`ifndef S2B_CONTINUOUS_EN
        foreach (vecs[i]) run_window(vecs[i].name, vecs[i].pat, vecs[i].exp);
`endif

        // Mid-window reset: partial window discarded, out cleared
        start = 1'b1;
        in = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_valid", out_valid, 0);
        chk("midrst_out", out, 0);
        @(negedge clk);
        rst_n = 1'b1;
        saw_valid = 1'b0;
        out_nz = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (out_valid) saw_valid = 1'b1;
            if (out != 0) out_nz = 1'b1;
        end
        chk("midrst_no_valid", saw_valid, 0);
        chk("midrst_out_stays0", out_nz, 0);
        in = 1'b0;

`ifndef S2B_CONTINUOUS_EN
        // Start pulsed again during RUN is ignored
        vcount = 0;
        first_at = -1;
        start = 1'b1;
        tick();
        for (int k = 1; k <= 20; k++) begin
            start = (k == 7);
            in = k[0];
            tick();
            if (out_valid) begin
                vcount++;
                first_at = k;
                chk("run_start_out", out, 8);
            end
        end
        start = 1'b0;
        in = 1'b0;
        chk("run_start_count", vcount, 1);
        chk("run_start_at", first_at, 16);

        // Start held high: the next window begins on the edge after out_valid
        vcount = 0;
        first_at = -1;
        second_at = -1;
        start = 1'b1;
        for (int k = 0; k <= 33; k++) begin
            in = k[0];
            tick();
            if (k == 17) chk("held_busy_again", busy, 1);
            if (out_valid) begin
                vcount++;
                if (vcount == 1) first_at = k;
                else second_at = k;
                chk("held_out", out, 8);
            end
        end
        start = 1'b0;
        in = 1'b0;
        tick();
        chk("held_count", vcount, 2);
        chk("held_first_at", first_at, 16);
        chk("held_second_at", second_at, 33);
`endif

        // Randomized run against a queue-based model
        rst_n = 1'b0;
        #2;
        @(negedge clk);
        rst_n = 1'b1;
        busy_m = 1'b0;
        out_m = '0;
        q.delete();
        p = 50;
        for (int c = 0; c < 1500; c++) begin
            if (c % N == 0) begin
                case ($urandom_range(0, 4))
                    0: p = 0;
                    1: p = 25;
                    2: p = 100;
                    default: p = $urandom_range(0, 100);
                endcase
            end
            start = ($urandom_range(0, 3) == 0);
            in = ($urandom_range(0, 99) < p);
            val_m = 1'b0;
            if (!busy_m) begin
                if (start) begin
                    busy_m = 1'b1;
                    q.delete();
                end
            end else begin
                q.push_back(int'(in));
                if (q.size() == N) begin
                    sum = q.sum();
                    out_m = (sum > N - 1) ? W'(N - 1) : W'(sum);
                    val_m = 1'b1;
                    q.delete();
`ifndef S2B_CONTINUOUS_EN
                    busy_m = 1'b0;
`endif
                end
            end
            tick();
            chk("rand_busy", busy, busy_m);
            chk("rand_valid", out_valid, val_m);
            chk("rand_out", out, out_m);
        end
        start = 1'b0;
        in = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
